// File: rtl/dual_port_ram_clr.sv
// Simple dual-port RAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a hardware clear engine.
module dual_port_ram_clr #(
   parameter int MEM_SIZE       = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_FIRST    = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clear_req,
   output logic                               ready,
   input  logic                               wr_en,
   input  logic [MEM_SIZE-1:0]                wr_addr,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
   input  logic                               rd_en,
   input  logic [MEM_SIZE-1:0]                rd_addr,
   output logic [DATA_WIDTH-1:0]              rd_data,
   output logic                               rd_valid
);

   localparam int unsigned DEPTH = 2**MEM_SIZE;
   localparam int unsigned NB    = DATA_WIDTH/BYTE_WIDTH;
   localparam logic [MEM_SIZE-1:0] LAST_ADDR = '1;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("dual_port_ram_clr: READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("dual_port_ram_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   logic [0:0]            state;
   logic [MEM_SIZE-1:0]   clr_addr;
   logic                  clearing;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  collide;
   logic [DATA_WIDTH-1:0] ram [DEPTH];
   logic [NB-1:0]         rd_ok;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] d1;
   logic                  v1;

   assign ready    = (state == ST_READY);
   assign clearing = (state == ST_CLEAR);
   assign wr_acc   = ready & wr_en & ~reset;
   assign rd_acc   = ready & rd_en & ~reset;
   assign collide  = wr_acc & rd_acc & (wr_addr == rd_addr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_addr <= '0;
      end else if (state == ST_CLEAR) begin
         if (clr_addr == LAST_ADDR) state <= ST_READY;
         else                       clr_addr <= clr_addr + 1'b1;
      end else if (clear_req) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (clearing) begin
         ram[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int unsigned i = 0; i < NB; i++)
            if (wr_be[i])
               ram[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // Without a reset-time clear, per-lane "written" flags make never-written lanes read as zero.
   if (CLEAR_ON_RESET == 0) begin : g_lane_ok
      logic [NB-1:0] lane_ok [DEPTH];
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int unsigned a = 0; a < DEPTH; a++) lane_ok[a] <= '0;
         end else if (wr_acc) begin
            lane_ok[wr_addr] <= lane_ok[wr_addr] | wr_be;
         end
      end
      assign rd_ok = lane_ok[rd_addr];
   end else begin : g_lane_all
      assign rd_ok = '1;
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (rd_ok[i])
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = ram[rd_addr][i*BYTE_WIDTH +: BYTE_WIDTH];
         if (WRITE_FIRST != 0 && collide && wr_be[i])
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         v1 <= rd_acc;
         if (rd_acc) d1 <= rd_word;
      end
   end

   if (READ_LATENCY == 1) begin : g_lat1
      assign rd_data  = d1;
      assign rd_valid = v1;
   end else begin : g_lat2
      always_ff @(posedge clk) begin
         if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= v1;
            if (v1) rd_data <= d1;
         end
      end
   end

endmodule
